// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory request arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_LDR  = 1'b1;
    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    // One-hot completion vector for a granted port index.
    function automatic logic [1:0] port_onehot(input logic port);
        logic [1:0] v;
        v = 2'b00;
        if (port == PORT_CPU) begin
            v[0] = 1'b1;
        end else begin
            v[1] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner selection. Purely combinational; the
// last-grant history register lives in the parent.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // A lone requester wins outright; on a tie the port not served last wins.
    always_comb begin
        grant_valid = |req;
        grant_idx   = PORT_CPU;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Shares the single memory-controller request port between the CPU (port 0)
// and a secondary master (port 1). Latches the winner's operands, holds the
// controller request until the matching completion pulse or a timeout, then
// returns data/acknowledge to the granted port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; pick a winner from req and latch its operands
// ISSUE | mc_request high, waiting for the type-matched response or timeout
// GAP   | one cycle with mc_request low before accepting the next request
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mc_request,
    output logic              mc_request_type,
    output logic [ADDR_W-1:0] mc_request_address,
    output logic [DATA_W-1:0] mc_memory_write,
    input  logic [DATA_W-1:0] mc_data_in,
    input  logic              mc_memory_ready,
    input  logic              mc_write_complete
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             grant_valid;
    logic             grant_idx;
    logic             resp_hit;
    logic             cnt_expired;

    rr_arbiter2 u_rr (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Only the completion pulse matching the latched type ends a transaction.
    always_comb begin
        resp_hit    = (mc_request_type == REQ_WRITE) ? mc_write_complete : mc_memory_ready;
        cnt_expired = (cnt == CNT_W'(TIMEOUT));
    end

    // Arbiter FSM with operand latches, timeout counter and registered outputs.
    // last_grant doubles as the current grant while in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            last_grant         <= PORT_LDR;
            cnt                <= '0;
            done               <= 2'b00;
            err                <= 1'b0;
            rdata              <= '0;
            busy               <= 1'b0;
            mc_request         <= 1'b0;
            mc_request_type    <= REQ_READ;
            mc_request_address <= '0;
            mc_memory_write    <= '0;
        end else begin
            done <= 2'b00;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state              <= ISSUE;
                        last_grant         <= grant_idx;
                        cnt                <= '0;
                        busy               <= 1'b1;
                        mc_request         <= 1'b1;
                        mc_request_type    <= req_type[grant_idx];
                        mc_request_address <= (grant_idx == PORT_LDR) ? req_addr1 : req_addr0;
                        mc_memory_write    <= (grant_idx == PORT_LDR) ? req_wdata1 : req_wdata0;
                    end
                end
                ISSUE: begin
                    // A real response wins over a timeout landing on the same cycle.
                    if (resp_hit) begin
                        state      <= GAP;
                        mc_request <= 1'b0;
                        done       <= port_onehot(last_grant);
                        rdata      <= (mc_request_type == REQ_READ) ? mc_data_in : '0;
                    end else if (cnt_expired) begin
                        state      <= GAP;
                        mc_request <= 1'b0;
                        done       <= port_onehot(last_grant);
                        err        <= 1'b1;
                        rdata      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    mc_request <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter with a short timeout so the abort
// path is reachable in a few cycles.
module tb_mem_request_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr0, req_addr1;
    logic [DATA_W-1:0] req_wdata0, req_wdata1;
    logic [1:0]        done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mc_request;
    logic              mc_request_type;
    logic [ADDR_W-1:0] mc_request_address;
    logic [DATA_W-1:0] mc_memory_write;
    logic [DATA_W-1:0] mc_data_in;
    logic              mc_memory_ready;
    logic              mc_write_complete;

    int n_checks = 0;
    int n_pass   = 0;

    mem_request_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req                (req),
        .req_type           (req_type),
        .req_addr0          (req_addr0),
        .req_addr1          (req_addr1),
        .req_wdata0         (req_wdata0),
        .req_wdata1         (req_wdata1),
        .done               (done),
        .err                (err),
        .rdata              (rdata),
        .busy               (busy),
        .mc_request         (mc_request),
        .mc_request_type    (mc_request_type),
        .mc_request_address (mc_request_address),
        .mc_memory_write    (mc_memory_write),
        .mc_data_in         (mc_data_in),
        .mc_memory_ready    (mc_memory_ready),
        .mc_write_complete  (mc_write_complete)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    initial begin
        int pulses;
        int early;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wd;

        reset = 1'b1;
        req = 2'b00; req_type = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        mc_data_in = '0; mc_memory_ready = 1'b0; mc_write_complete = 1'b0;
        step();
        step();

        // Reset state
        check("rst_mc_request", 32'(mc_request), 32'h0);
        check("rst_done",       32'(done),       32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_err",        32'(err),        32'h0);
        check("rst_rdata",      32'(rdata),      32'h0);
        check("rst_mc_addr",    32'(mc_request_address), 32'h0);
        check("rst_mc_wdata",   32'(mc_memory_write),    32'h0);
        check("rst_mc_type",    32'(mc_request_type),    32'h0);
        reset = 1'b0;
        step();

        // Tie then alternation: both ports write continuously, 1-cycle response
        req_addr0 = 16'h0100; req_wdata0 = 16'hAAAA;
        req_addr1 = 16'h0200; req_wdata1 = 16'h5555;
        req_type  = 2'b11;
        req       = 2'b11;
        step();
        for (int t = 0; t < 4; t++) begin
            exp_addr = (t % 2 == 0) ? 16'h0100 : 16'h0200;
            exp_wd   = (t % 2 == 0) ? 16'hAAAA : 16'h5555;
            check("alt_mc_request", 32'(mc_request), 32'h1);
            check("alt_mc_addr",    32'(mc_request_address), 32'(exp_addr));
            check("alt_mc_wdata",   32'(mc_memory_write),    32'(exp_wd));
            check("alt_mc_type",    32'(mc_request_type),    32'h1);
            mc_write_complete = 1'b1;
            step();
            mc_write_complete = 1'b0;
            check("alt_done", 32'(done), (t % 2 == 0) ? 32'h1 : 32'h2);
            check("alt_err",  32'(err),  32'h0);
            check("alt_gap_request_low", 32'(mc_request), 32'h0);
            if (t == 3) req = 2'b00;
            step();
            check("alt_idle_request_low", 32'(mc_request), 32'h0);
            step();
            check("alt_next_request", 32'(mc_request), (t < 3) ? 32'h1 : 32'h0);
        end

        // Single read, port 0, response sampled 4 cycles after mc_request rises
        req_type = 2'b00; req_addr0 = 16'h0012;
        req = 2'b01;
        step();
        check("rd_mc_request", 32'(mc_request), 32'h1);
        check("rd_mc_addr",    32'(mc_request_address), 32'h0012);
        check("rd_busy",       32'(busy), 32'h1);
        early = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done != 2'b00) early++;
        end
        check("rd_no_early_done", 32'(early), 32'h0);
        mc_data_in = 16'hBEEF; mc_memory_ready = 1'b1;
        step();
        mc_memory_ready = 1'b0; mc_data_in = 16'h0000;
        req = 2'b00;
        check("rd_done",  32'(done),  32'h1);
        check("rd_rdata", 32'(rdata), 32'hBEEF);
        check("rd_err",   32'(err),   32'h0);
        check("rd_mc_request_low", 32'(mc_request), 32'h0);
        step();
        check("rd_done_one_cycle", 32'(done), 32'h0);
        check("rd_busy_clear",     32'(busy), 32'h0);

        // Wrong-type response: write_complete during a port 1 read is ignored
        req_addr1 = 16'h0345; req_type = 2'b00;
        req = 2'b10;
        step();
        check("wt_mc_addr", 32'(mc_request_address), 32'h0345);
        mc_write_complete = 1'b1;
        step();
        mc_write_complete = 1'b0;
        check("wt_ignored_done",    32'(done),       32'h0);
        check("wt_still_requesting", 32'(mc_request), 32'h1);
        step();
        mc_data_in = 16'h1234; mc_memory_ready = 1'b1;
        step();
        mc_memory_ready = 1'b0; mc_data_in = 16'h0000;
        req = 2'b00;
        check("wt_done",  32'(done),  32'h2);
        check("wt_rdata", 32'(rdata), 32'h1234);
        check("wt_err",   32'(err),   32'h0);
        step();
        step();

        // Timeout: no response, abort TIMEOUT+1 cycles after mc_request rises
        req_addr0 = 16'h0777; req_type = 2'b00;
        req = 2'b01;
        step();
        check("to_mc_request", 32'(mc_request), 32'h1);
        early = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            if (done != 2'b00 || err != 1'b0) early++;
        end
        check("to_no_early_done", 32'(early), 32'h0);
        step();
        req = 2'b00;
        check("to_done",  32'(done),  32'h1);
        check("to_err",   32'(err),   32'h1);
        check("to_rdata", 32'(rdata), 32'h0);
        check("to_mc_request_low", 32'(mc_request), 32'h0);
        step();
        check("to_err_one_cycle", 32'(err), 32'h0);
        step();
        // Next request after timeout proceeds normally (port 1 write)
        req_addr1 = 16'h0ABC; req_wdata1 = 16'hC3C3; req_type = 2'b10;
        req = 2'b10;
        step();
        check("to_next_wdata", 32'(mc_memory_write), 32'hC3C3);
        mc_write_complete = 1'b1;
        step();
        mc_write_complete = 1'b0;
        req = 2'b00;
        check("to_next_done", 32'(done), 32'h2);
        check("to_next_err",  32'(err),  32'h0);
        // Response pulse arriving in GAP is ignored
        mc_memory_ready = 1'b1; mc_write_complete = 1'b1;
        step();
        mc_memory_ready = 1'b0; mc_write_complete = 1'b0;
        check("gap_pulse_ignored", 32'(done), 32'h0);
        step();

        // Early drop: port 0 drops req one cycle after grant; still completes once
        req_addr0 = 16'h0055; req_type = 2'b00;
        req = 2'b01;
        step();
        step();
        req = 2'b00;
        step();
        pulses = 0;
        mc_data_in = 16'h0F0F; mc_memory_ready = 1'b1;
        step();
        mc_memory_ready = 1'b0; mc_data_in = 16'h0000;
        if (done == 2'b01) pulses++;
        check("ed_rdata", 32'(rdata), 32'h0F0F);
        for (int i = 0; i < 5; i++) begin
            step();
            if (done != 2'b00) pulses++;
        end
        check("ed_done_pulses", 32'(pulses), 32'h1);

        // Reset two cycles into a port 0 read: abandoned, then tie grants port 0
        req_addr0 = 16'h0999; req_addr1 = 16'h0888; req_type = 2'b00;
        req = 2'b01;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("mr_done",       32'(done),       32'h0);
        check("mr_mc_request", 32'(mc_request), 32'h0);
        check("mr_busy",       32'(busy),       32'h0);
        check("mr_rdata",      32'(rdata),      32'h0);
        check("mr_mc_addr",    32'(mc_request_address), 32'h0);
        reset = 1'b0;
        req = 2'b11;
        step();
        check("mr_tie_request", 32'(mc_request), 32'h1);
        check("mr_tie_port0",   32'(mc_request_address), 32'h0999);
        mc_data_in = 16'h7777; mc_memory_ready = 1'b1;
        step();
        mc_memory_ready = 1'b0; mc_data_in = 16'h0000;
        req = 2'b00;
        check("mr_tie_done", 32'(done), 32'h1);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Two-port arbiter that shares the single Arduino memory-controller request port between the x3q16 CPU (port 0) and a second master such as a UART boot loader or DMA engine (port 1). It latches one requester's address, type and write data, drives the controller's request handshake, and routes the read data or write acknowledgement back to the granted requester. A timeout guarantees forward progress if the external memory never answers. It sits between the requesters and `memory_controller_arduino`, replacing the direct CPU-to-controller wiring.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 1023, cycles to wait for a controller response before aborting; legal range 1..65535
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `req[1:0]`  in  2  per-port request level; port 0 = CPU, port 1 = loader
- `req_type[1:0]`  in  2  per-port type; 0 = read, 1 = write
- `req_addr0`, `req_addr1`  in  ADDR_W  per-port address
- `req_wdata0`, `req_wdata1`  in  DATA_W  per-port write data
- `done[1:0]`  out  2  one-cycle completion pulse, per port
- `err`  out  1  qualifies `done`; 1 = timed out
- `rdata`  out  DATA_W  read data, valid with `done`
- `busy`  out  1  transaction in flight
- `mc_request`  out  1  to controller `request`
- `mc_request_type`  out  1  to controller `request_type`
- `mc_request_address`  out  ADDR_W  to controller `request_address`
- `mc_memory_write`  out  DATA_W  to controller `memory_write`
- `mc_data_in`  in  DATA_W  from controller `data_out`
- `mc_memory_ready`  in  1  read-complete pulse
- `mc_write_complete`  in  1  write-complete pulse

## Operation
- FSM states: IDLE, ISSUE, GAP.
- **IDLE:** if any `req` bit is high, select a winner:
  - Only one request pending: that port wins.
  - Both pending: the port not granted last wins.
  - `last_grant` resets to 1, so port 0 wins the first tie after reset.
  - On selection: latch the winner's address, type and wdata into `mc_*`; set `last_grant` to the winner; clear the timeout counter; go to ISSUE.
- **ISSUE:** `mc_request` is held high and the latched `mc_*` values are held stable.
  - Read completes on `mc_memory_ready`. A `mc_write_complete` during a read is ignored, and vice versa.
  - On completion: capture `mc_data_in` into `rdata` (reads; writes leave `rdata` at 0); pulse `done[grant]` with `err = 0`; go to GAP.
  - The counter increments every ISSUE cycle. When it reaches `TIMEOUT` with no response: pulse `done[grant]` with `err = 1` and `rdata = 0`; go to GAP.
- **GAP:** exactly one cycle with `mc_request` low, then IDLE.
- Requester rules:
  - Hold `req` and its operands stable until its `done` pulse.
  - Drop `req` in the cycle `done` is seen, unless it wants another transaction.
  - `req` still high when IDLE is re-entered counts as a new request.
- A requester dropping `req` while granted does not abort; the transaction completes and `done` still pulses.
- `busy` is high in ISSUE and GAP.

## Timing
- Reset: state IDLE, `last_grant` = 1, counter 0. All outputs 0: `done`, `err`, `rdata`, `busy`, `mc_request`, `mc_request_type`, `mc_request_address`, `mc_memory_write`.
- All outputs are registered.
- `req` sampled high in IDLE at cycle N → `mc_request` high at N+1.
- Response sampled at cycle M → `done` and `rdata` at M+1; `mc_request` low at M+1 (GAP).
- IDLE at M+2; next `mc_request` high at M+3 at the earliest. Back-to-back throughput is response latency + 3 cycles.
- A response in the first ISSUE cycle is legal: minimum request-to-`done` latency is 2 cycles.
- Timeout: `done` and `err` appear `TIMEOUT` + 1 cycles after `mc_request` rises.
- Reset asserted mid-transaction: the transaction is abandoned with no `done`, and `mc_request` is low in the cycle after reset is sampled.
- A response pulse arriving in GAP or IDLE is ignored.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` (IDLE/ISSUE/GAP)
  - constants `PORT_CPU = 0`, `PORT_LDR = 1`, `REQ_READ = 0`, `REQ_WRITE = 1`
- Sub-module `rr_arbiter2`: `req[1:0]` plus `last_grant` → `grant_valid`, `grant_idx`. Purely combinational; `last_grant` stays in the parent.
- The parent holds the FSM, the operand latches and the timeout counter, sized `$clog2(TIMEOUT+1)`.

## Test plan
- **Single read:** port 0 reads addr 0x0012; controller returns 0xBEEF after 4 cycles. Expect `done[0]` at request+6, `rdata` = 0xBEEF, `err` = 0, `mc_request` low afterwards.
- **Tie then alternation:** both ports request writes every cycle for 4 transactions. Grant order 0,1,0,1; each `mc_memory_write` matches the granted port's `wdata`; exactly one GAP cycle between requests.
- **Wrong-type response:** port 1 reads; the controller pulses `mc_write_complete` first, then `mc_memory_ready` with 0x1234. The first pulse is ignored; `done[1]` follows the second with `rdata` = 0x1234.
- **Timeout:** `TIMEOUT` = 8; the controller never responds. Expect `done` and `err` both high 9 cycles after `mc_request` rises, `rdata` = 0; the next request proceeds normally.
- **Reset mid-ISSUE:** assert `reset` 2 cycles into a read. No `done` pulse; all outputs 0 the following cycle; after release, a tie grants port 0.
- **Early drop:** port 0 drops `req` one cycle after the grant. The transaction still completes and `done[0]` pulses once.
